as_gpio_uart_tap: RTL and testbench
===================================

// Module: as_gpio_uart_tap
//
// PURPOSE
// Downstream consumer of the core's GPIO store port (cs/gpioAddr/gpio). Captures every
// GPIO write into a small FIFO and serialises each entry as a UART-style frame on one pin,
// so silicon and FPGA builds can report test results without a bench. It also latches
// sticky pass/fail flags from the self-test signature addresses.
//
// PARAMETERS
// ADDR_W      gpio_addr_width (as_pack)  width of gpioAddr_i
// DATA_W      nr_gpios (as_pack)         width of gpio_i
// FIFO_DEPTH  4                          capture entries; power of 2, >= 2
// BAUD_DIV    16                         clk_i cycles per serial bit, >= 2
// FAIL_ADDR   4                          write to this address sets fail_o
// PASS_ADDR   8                          write to this address sets pass_o
//
// PORTS
// clk_i       in   1                     system clock, rising edge
// rst_i       in   1                     asynchronous reset, active low
// cs_i        in   1                     GPIO write strobe from core
// gpioAddr_i  in   ADDR_W                GPIO write address
// gpio_i      in   DATA_W                GPIO write data
// tx_o        out  1                     serial frame output, idles high
// busy_o      out  1                     FIFO non-empty or frame in progress
// level_o     out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// ovf_o       out  1                     sticky: a write was dropped (FIFO full)
// fail_o      out  1                     sticky: write to FAIL_ADDR seen
// pass_o      out  1                     sticky: write to PASS_ADDR seen
//
// BEHAVIOUR
// - Reset (rst_i=0, async): tx_o=1, busy_o=0, level_o=0, ovf_o=fail_o=pass_o=0; FIFO
//   emptied, FSM to IDLE, baud counter 0. Reset mid-frame aborts it; tx_o high at once.
// - Capture: each rising edge with cs_i=1 pushes {gpioAddr_i,gpio_i}. cs_i high for k
//   cycles pushes k entries.
// - Full: push while full and no pop that cycle -> entry dropped, ovf_o=1 next edge.
//   Push and pop in same cycle at full -> both happen, level unchanged, no overflow.
// - Flags: fail_o/pass_o set on the edge where cs_i=1 and gpioAddr_i matches, regardless
//   of FIFO state (set even if the entry is dropped). Both may be set; neither clears
//   except by reset.
// - FSM: IDLE -> START -> ADDR -> DATA -> STOP -> IDLE (or -> START if FIFO non-empty).
//   IDLE: if FIFO non-empty, pop head into shift register, go START. Pop and load occur
//   on the same edge. Bits: START=0; ADDR: ADDR_W bits LSB first; DATA: DATA_W bits
//   LSB first; STOP=1. Each bit held exactly BAUD_DIV cycles; baud counter reloads at
//   every bit boundary. Frame length = (ADDR_W+DATA_W+2)*BAUD_DIV cycles.
// - Latency: push into empty FIFO at edge N with FSM idle -> pop at edge N+1, tx_o=0
//   from edge N+1. Back-to-back entries: next START begins on the edge ending STOP, with
//   no idle bit.
// - tx_o is registered (no combinational path from FSM decode).
// - busy_o = (state!=IDLE) | (level!=0), registered-equivalent (from flops only).
// - level_o counts stored entries only; the entry in the shift register is excluded.
//
// STRUCTURE
// - as_pack additions: localparams GPIO_FAIL_ADDR=4, GPIO_PASS_ADDR=8, UART_BAUD_DIV=16;
//   typedef enum logic [2:0] {TX_IDLE,TX_START,TX_ADDR,TX_DATA,TX_STOP} tx_state_t;
//   typedef struct packed {addr; data} gpio_wr_t.
// - One sub-module: as_sync_fifo (parameterised WIDTH/DEPTH, push/pop/full/empty/level,
//   async active-low reset); reused by other peripherals later.
// - Top holds FSM, baud counter, bit counter, shift register and flag flops.
//
// TESTING (BAUD_DIV=4, ADDR_W=4, DATA_W=8 unless noted)
// 1 Reset, idle 50 cycles -> tx_o=1, busy_o=0, all flags 0, level_o=0.
// 2 One write addr=0x3 data=0xA5 -> tx_o low 4 cycles from next edge, then bits
//   1,1,0,0 then 1,0,1,0,0,1,0,1, stop high; frame 56 cycles; busy_o falls after stop.
// 3 cs_i high 6 consecutive cycles, FIFO_DEPTH=4, FSM idle -> first pops, 4 stored,
//   6th dropped, ovf_o=1; exactly 5 frames emitted back to back, data in order.
// 4 Write addr=4 data=0x01 -> fail_o=1 next edge, pass_o=0; frame still sent; later
//   write addr=8 -> pass_o=1 with fail_o still 1.
// 5 Fill FIFO, then push with simultaneous pop at STOP end -> level_o stays 4, ovf_o=0.
// 6 Assert rst_i=0 mid-DATA -> tx_o=1 same time step, level_o=0; after release no
//   residual frame, flags 0.

Source files
------------

// File: rtl/as_pack.sv
// Purpose : shared constants and types for the as_* core peripherals.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package as_pack;

    // Core GPIO store-port geometry.
    localparam int gpio_addr_width = 4;
    localparam int nr_gpios        = 8;

    // Self-test signature addresses and default UART bit period.
    localparam int GPIO_FAIL_ADDR = 4;
    localparam int GPIO_PASS_ADDR = 8;
    localparam int UART_BAUD_DIV  = 16;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_ADDR,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef struct packed {
        logic [gpio_addr_width-1:0] addr;
        logic [nr_gpios-1:0]        data;
    } gpio_wr_t;

endpackage

// File: rtl/as_sync_fifo.sv
// Purpose : generic single-clock FIFO, combinational head (read from flops).
// Latency : push visible at head / in level on the next edge.
// Backpressure: push while full is dropped unless a pop happens the same edge.
//
// Ports: clk_i/rst_i (async active-low), push/push_dat, pop/head_dat,
//        full, empty, level (stored entry count).
module as_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign level    = cnt;
    assign head_dat = mem[rd_ptr];

    // A pop frees a slot in the same edge, so push at full is accepted then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/as_gpio_uart_tap.sv
// Purpose : captures core GPIO writes and serialises each as a UART-style frame
//           (start, addr LSB-first, data LSB-first, stop); latches pass/fail flags.
// Latency : write at edge N into empty FIFO with idle line -> start bit from edge N+1.
// Backpressure: none toward the core; writes arriving at a full FIFO are dropped, ovf_o set.
//
// Ports: clk_i, rst_i (async active-low), cs_i/gpioAddr_i/gpio_i (write strobe),
//        tx_o (serial, idles high), busy_o, level_o, ovf_o/fail_o/pass_o (sticky).
module as_gpio_uart_tap
    import as_pack::*;
#(
    parameter int ADDR_W     = gpio_addr_width,
    parameter int DATA_W     = nr_gpios,
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD_DIV   = UART_BAUD_DIV,
    parameter int FAIL_ADDR  = GPIO_FAIL_ADDR,
    parameter int PASS_ADDR  = GPIO_PASS_ADDR
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cs_i,
    input  logic [ADDR_W-1:0]             gpioAddr_i,
    input  logic [DATA_W-1:0]             gpio_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          ovf_o,
    output logic                          fail_o,
    output logic                          pass_o
);
    localparam int FW = ADDR_W + DATA_W;
    localparam int BW = $clog2(BAUD_DIV);
    localparam int CW = $clog2((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1;

    tx_state_t         state, state_nxt;
    logic [BW-1:0]     baud_cnt, baud_nxt;
    logic [CW-1:0]     bit_cnt, bit_nxt;
    logic [FW-1:0]     shift, shift_nxt;
    logic              tx_q, tx_nxt;
    logic              pop;
    logic              full;
    logic              empty;
    logic [FW-1:0]     head_dat;
    logic [FW-1:0]     load_dat;
    logic              bit_end;
    logic              ovf_q, fail_q, pass_q;

    as_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (cs_i),
        .push_dat ({gpioAddr_i, gpio_i}),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (full),
        .empty    (empty),
        .level    (level_o)
    );

    // Shift register holds {data, addr} so a plain right shift emits addr first.
    assign load_dat = {head_dat[DATA_W-1:0], head_dat[FW-1:DATA_W]};
    assign bit_end  = (baud_cnt == BW'(BAUD_DIV - 1));

    always_comb begin
        state_nxt = state;
        baud_nxt  = bit_end ? '0 : baud_cnt + BW'(1);
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        tx_nxt    = tx_q;
        pop       = 1'b0;
        case (state)
            TX_IDLE: begin
                baud_nxt = '0;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = load_dat;
                    state_nxt = TX_START;
                    tx_nxt    = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_nxt = TX_ADDR;
                    bit_nxt   = '0;
                    tx_nxt    = shift[0];
                    shift_nxt = shift >> 1;
                end
            end
            TX_ADDR: begin
                if (bit_end) begin
                    // Last addr bit hands over straight to data bit 0.
                    tx_nxt    = shift[0];
                    shift_nxt = shift >> 1;
                    if (bit_cnt == CW'(ADDR_W - 1)) begin
                        state_nxt = TX_DATA;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_cnt + CW'(1);
                    end
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == CW'(DATA_W - 1)) begin
                        state_nxt = TX_STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        tx_nxt    = shift[0];
                        shift_nxt = shift >> 1;
                        bit_nxt   = bit_cnt + CW'(1);
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    // Back-to-back frames: next start bit begins with no idle gap.
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_nxt = load_dat;
                        state_nxt = TX_START;
                        tx_nxt    = 1'b0;
                    end else begin
                        state_nxt = TX_IDLE;
                        tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = TX_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shift    <= shift_nxt;
            tx_q     <= tx_nxt;
        end
    end

    // Flags look at the raw strobe, so they set even when the entry is dropped.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf_q  <= 1'b0;
            fail_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            if (cs_i && full && !pop) begin
                ovf_q <= 1'b1;
            end
            if (cs_i && (gpioAddr_i == ADDR_W'(FAIL_ADDR))) begin
                fail_q <= 1'b1;
            end
            if (cs_i && (gpioAddr_i == ADDR_W'(PASS_ADDR))) begin
                pass_q <= 1'b1;
            end
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = (state != TX_IDLE) || (level_o != '0);
    assign ovf_o  = ovf_q;
    assign fail_o = fail_q;
    assign pass_o = pass_q;

endmodule

// File: tb/tb_as_gpio_uart_tap.sv
// Purpose : self-checking bench for as_gpio_uart_tap (BAUD_DIV=4, ADDR_W=4, DATA_W=8, depth 4).
// Latency : n/a.
// Backpressure: n/a.
module tb_as_gpio_uart_tap;
    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int DEP  = 4;
    localparam int BD   = 4;
    localparam int NBIT = AW + DW + 2;
    localparam int FLEN = NBIT * BD;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          cs_i  = 1'b0;
    logic [AW-1:0] gpio_addr = '0;
    logic [DW-1:0] gpio_dat  = '0;
    logic          tx_o, busy_o, ovf_o, fail_o, pass_o;
    logic [2:0]    level_o;

    as_gpio_uart_tap #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEP), .BAUD_DIV(BD),
        .FAIL_ADDR(4), .PASS_ADDR(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cs_i(cs_i), .gpioAddr_i(gpio_addr),
        .gpio_i(gpio_dat), .tx_o(tx_o), .busy_o(busy_o), .level_o(level_o),
        .ovf_o(ovf_o), .fail_o(fail_o), .pass_o(pass_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: queue + frame position ----------------
    logic [AW+DW-1:0] m_q[$];
    logic [AW+DW-1:0] m_cur = '0;
    bit               m_act = 1'b0;
    int               m_pos = 0;
    bit               m_ovf = 1'b0, m_fail = 1'b0, m_pass = 1'b0;

    // Line level at bit index idx of the frame carrying entry e = {addr, data}.
    function automatic logic frame_bit(input logic [AW+DW-1:0] e, input int idx);
        if (idx == 0)       return 1'b0;
        if (idx <= AW)      return e[DW + idx - 1];
        if (idx <= AW + DW) return e[idx - AW - 1];
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk_i or negedge rst_i);
        if (!rst_i) begin
            m_q.delete();
            m_act = 1'b0; m_pos = 0;
            m_ovf = 1'b0; m_fail = 1'b0; m_pass = 1'b0;
        end else begin
            if (m_act) begin
                m_pos++;
                if (m_pos == FLEN) m_act = 1'b0;
            end
            if (!m_act && m_q.size() > 0) begin
                m_cur = m_q.pop_front();
                m_act = 1'b1;
                m_pos = 0;
            end
            if (cs_i) begin
                if (gpio_addr == 4'd4) m_fail = 1'b1;
                if (gpio_addr == 4'd8) m_pass = 1'b1;
                if (m_q.size() < DEP) m_q.push_back({gpio_addr, gpio_dat});
                else                  m_ovf = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk_i);
        if (chk_en) begin
            chk("m_tx",    32'(tx_o),    32'(m_act ? frame_bit(m_cur, m_pos / BD) : 1'b1));
            chk("m_busy",  32'(busy_o),  32'(m_act || (m_q.size() != 0)));
            chk("m_level", 32'(level_o), 32'(m_q.size()));
            chk("m_ovf",   32'(ovf_o),   32'(m_ovf));
            chk("m_fail",  32'(fail_o),  32'(m_fail));
            chk("m_pass",  32'(pass_o),  32'(m_pass));
        end
    end

    // ---------------- serial receiver: decodes frames from tx_o ----------------
    logic [AW+DW-1:0] rx_q[$];
    logic [NBIT-1:0]  rx_bits = '0;
    bit               rx_on = 1'b0;
    int               rx_cnt = 0;

    initial forever begin
        @(negedge clk_i);
        if (!rst_i) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (tx_o == 1'b0) begin
                rx_on  = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % BD == 1) begin
                rx_bits[rx_cnt / BD] = tx_o;
                if (rx_cnt / BD == NBIT - 1) begin
                    rx_on = 1'b0;
                    chk("rx_start", 32'(rx_bits[0]), 32'd0);
                    chk("rx_stop",  32'(rx_bits[NBIT-1]), 32'd1);
                    rx_q.push_back({rx_bits[AW:1], rx_bits[AW+DW:AW+1]});
                end
            end
        end
    end

    logic [AW+DW-1:0] exp_q[$];

    task automatic check_rx(input string name);
        chk({name, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            chk($sformatf("%s_frame%0d", name, i),
                32'((i < rx_q.size()) ? rx_q[i] : 12'hxxx), 32'(exp_q[i]));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        cs_i  = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        rx_q.delete();
    endtask

    // Drive one write strobe for one cycle; returns at the negedge after the edge.
    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cs_i = 1'b1; gpio_addr = a; gpio_dat = d;
        @(negedge clk_i);
        cs_i = 1'b0;
    endtask

    logic [NBIT-1:0] t2_exp;
    logic [AW-1:0]   t3_a[6];
    logic [DW-1:0]   t3_d[6];

    initial begin
        // 1: reset and idle
        @(negedge clk_i);
        do_reset();
        chk_en = 1'b1;
        repeat (50) @(negedge clk_i);
        chk("t1_tx", 32'(tx_o), 32'd1);
        chk("t1_busy", 32'(busy_o), 32'd0);
        chk("t1_level", 32'(level_o), 32'd0);
        chk("t1_flags", 32'({ovf_o, fail_o, pass_o}), 32'd0);

        // 2: single frame addr 3 data A5, bit-level literal timing
        t2_exp = 14'b11_0100_1010_0110; // b13..b0: stop, data MSB..LSB, addr MSB..LSB, start
        wr(4'h3, 8'hA5);
        repeat (2) @(negedge clk_i);
        for (int b = 0; b < NBIT; b++) begin
            if (b != 0) repeat (BD) @(negedge clk_i);
            chk($sformatf("t2_bit%0d", b), 32'(tx_o), 32'(t2_exp[b]));
        end
        repeat (2) @(negedge clk_i);
        chk("t2_busy_last", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        chk("t2_busy_after", 32'(busy_o), 32'd0);
        chk("t2_tx_idle", 32'(tx_o), 32'd1);
        repeat (5) @(negedge clk_i);
        exp_q.push_back(12'h3A5);
        check_rx("t2");

        // 3: six consecutive writes, one dropped
        t3_a = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7};
        t3_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        cs_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            gpio_addr = t3_a[i]; gpio_dat = t3_d[i];
            @(negedge clk_i);
        end
        cs_i = 1'b0;
        chk("t3_level", 32'(level_o), 32'd4);
        chk("t3_ovf", 32'(ovf_o), 32'd1);
        repeat (5 * FLEN + 20) @(negedge clk_i);
        for (int i = 0; i < 5; i++) exp_q.push_back({t3_a[i], t3_d[i]});
        check_rx("t3");

        // 4: fail then pass signature writes
        do_reset();
        wr(4'h4, 8'h01);
        chk("t4_fail", 32'(fail_o), 32'd1);
        chk("t4_pass0", 32'(pass_o), 32'd0);
        repeat (FLEN + 10) @(negedge clk_i);
        wr(4'h8, 8'h02);
        chk("t4_pass", 32'(pass_o), 32'd1);
        chk("t4_fail_kept", 32'(fail_o), 32'd1);
        repeat (FLEN + 10) @(negedge clk_i);
        exp_q.push_back(12'h401);
        exp_q.push_back(12'h802);
        check_rx("t4");

        // 5: full FIFO, push coinciding with pop at end of stop bit
        do_reset();
        cs_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            gpio_addr = 4'(i + 9); gpio_dat = 8'(8'hC0 + i);
            exp_q.push_back({4'(i + 9), 8'(8'hC0 + i)});
            @(negedge clk_i);
        end
        cs_i = 1'b0;
        repeat (FLEN - 4) @(negedge clk_i);
        chk("t5_level_pre", 32'(level_o), 32'd4);
        wr(4'hF, 8'h5A);
        exp_q.push_back(12'hF5A);
        chk("t5_level", 32'(level_o), 32'd4);
        chk("t5_ovf", 32'(ovf_o), 32'd0);
        repeat (5 * FLEN + 20) @(negedge clk_i);
        check_rx("t5");

        // 6: reset in the middle of the data field
        wr(4'h4, 8'h0F);
        wr(4'hA, 8'h3C);
        wr(4'h8, 8'hF0);
        repeat (25) @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        chk("t6_tx_rst", 32'(tx_o), 32'd1);
        chk("t6_level_rst", 32'(level_o), 32'd0);
        chk("t6_busy_rst", 32'(busy_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (100) @(negedge clk_i);
        chk("t6_tx", 32'(tx_o), 32'd1);
        chk("t6_flags", 32'({ovf_o, fail_o, pass_o}), 32'd0);
        check_rx("t6");

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
